// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage: multi-cycle data memory handshake, MEM/WB
//            register, upstream stall and forwarding outputs.
// Option   : MEM_ALIGN_CHECK_EN - reject odd-address loads/stores with err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] alu_out,
  input  logic [15:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [2:0]  rd,
  input  logic        halt_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        stall_out,
  output logic [15:0] ex_mem_data,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_halt,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic [15:0] mem_wb_data,
  output logic        err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_rd_q, is_rd_d;
  logic        is_wr_q, is_wr_d;
  logic [2:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        halt_q, halt_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_halt_q, wb_halt_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic w_memop, w_illegal, w_misalign;

  assign w_memop   = mem_read | mem_write;
  assign w_illegal = mem_read & mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = alu_out[0];
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_rd_d    = is_rd_q;
    is_wr_d    = is_wr_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    halt_d     = halt_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_halt_d  = wb_halt_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    stall_out  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (w_memop && !w_illegal && w_misalign) begin
            err_d = 1'b1;
          end else if (w_memop && !w_illegal) begin
            state_d   = S_REQ;
            stall_out = 1'b1;
            cnt_d     = '0;
            addr_d    = alu_out;
            wdata_d   = store_data;
            is_rd_d   = mem_read;
            is_wr_d   = mem_write;
            rd_d      = rd;
            rw_d      = reg_write;
            halt_d    = halt_in;
          end else begin
            // Illegal read+write control falls through as a plain ALU op.
            err_d      = err_q | w_illegal;
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out;
            wb_rd_d    = rd;
            wb_rw_d    = reg_write;
            wb_halt_d  = halt_in;
          end
        end
      end
      S_REQ: begin
        stall_out = 1'b1;
        mem_rd    = is_rd_q;
        mem_wr    = is_wr_q;
        state_d   = mem_done ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (mem_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Completion is shared by the REQ and BUSY states.
    if (state_q != S_IDLE && mem_done) begin
      wb_valid_d = 1'b1;
      wb_data_d  = is_rd_q ? mem_rdata : addr_q;
      wb_rd_d    = rd_q;
      wb_rw_d    = rw_q;
      wb_halt_d  = halt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_rd_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      halt_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_halt_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_rd_q    <= is_rd_d;
      is_wr_q    <= is_wr_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      halt_q     <= halt_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_halt_q  <= wb_halt_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign ex_mem_data  = alu_out;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_halt      = wb_halt_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_wb_data  = wb_data_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, mem_read, mem_write, reg_write, halt_in, mem_done;
  logic [15:0] alu_out, store_data, mem_rdata;
  logic [2:0]  rd;
  logic [15:0] mem_addr, mem_wdata, ex_mem_data, wb_data, mem_wb_data;
  logic        mem_rd, mem_wr, stall_out, wb_valid, wb_reg_write, wb_halt, err;
  logic [2:0]  wb_rd;

  int n_total = 0;
  int n_pass  = 0;
  int rd_pulses;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_out(alu_out),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd), .halt_in(halt_in), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .stall_out(stall_out),
    .ex_mem_data(ex_mem_data), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_wb_data(mem_wb_data), .err(err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; halt_in = 0;
    mem_done = 0; alu_out = '0; store_data = '0; mem_rdata = '0; rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ex_mem_data", ex_mem_data, 0);
    tick();
    rst_n = 1'b1;

    // ADD: one-cycle latency, no stall
    in_valid = 1; alu_out = 16'h1234; rd = 3; reg_write = 1;
    @(negedge clk);
    chk("add_stall", stall_out, 0);
    chk("add_fwd", ex_mem_data, 16'h1234);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_data, 16'h1234);
    chk("add_wb_rd", wb_rd, 3);
    chk("add_wb_rw", wb_reg_write, 1);
    chk("add_mem_wb_data", mem_wb_data, 16'h1234);
    chk("add_stall2", stall_out, 0);
    tick();
    @(negedge clk);
    chk("idle_bubble", wb_valid, 0);
    chk("idle_hold_data", wb_data, 16'h1234);

    // LD 0x0010: IDLE, REQ, three BUSY waits, done in fourth BUSY cycle
    tick();
    in_valid = 1; alu_out = 16'h0010; rd = 5; reg_write = 1; mem_read = 1;
    rd_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i == 5) begin mem_done = 1; mem_rdata = 16'hBEEF; end
      @(negedge clk);
      if (mem_rd) rd_pulses++;
      chk($sformatf("ld_stall_c%0d", i), stall_out, (i < 5) ? 1 : 0);
      chk($sformatf("ld_mem_rd_c%0d", i), mem_rd, (i == 1) ? 1 : 0);
      if (i == 1) chk("ld_addr_req", mem_addr, 16'h0010);
      if (i == 3) chk("ld_addr_busy", mem_addr, 16'h0010);
      if (i >= 1) chk($sformatf("ld_bubble_c%0d", i), wb_valid, 0);
    end
    chk("ld_rd_pulses", 16'(rd_pulses), 1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_wb_rd", wb_rd, 5);
    chk("ld_err", err, 0);

    // ST 0x0020 with done in REQ
    tick();
    in_valid = 1; alu_out = 16'h0020; store_data = 16'h00AA; rd = 2; mem_write = 1;
    @(negedge clk);
    chk("st_stall_c0", stall_out, 1);
    chk("st_mem_wr_c0", mem_wr, 0);
    tick();
    mem_done = 1;
    @(negedge clk);
    chk("st_mem_wr_req", mem_wr, 1);
    chk("st_mem_rd_req", mem_rd, 0);
    chk("st_wdata_req", mem_wdata, 16'h00AA);
    chk("st_addr_req", mem_addr, 16'h0020);
    chk("st_stall_req", stall_out, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("st_stall_after", stall_out, 0);
    chk("st_mem_wr_after", mem_wr, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_rw", wb_reg_write, 0);
    chk("st_wb_data", wb_data, 16'h0020);

    // LD with no mem_done: timeout after 4 BUSY cycles
    tick();
    in_valid = 1; alu_out = 16'h0030; rd = 4; reg_write = 1; mem_read = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk($sformatf("to_stall_c%0d", i), stall_out, (i < 5) ? 1 : 0);
      chk($sformatf("to_err_c%0d", i), err, 0);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_stall", stall_out, 0);
    chk("to_wb_valid", wb_valid, 0);
    chk("to_wb_hold", wb_data, 16'h0020);
    tick();
    @(negedge clk);
    chk("to_err_sticky", err, 1);

    // Reset asserted in BUSY, then a stray mem_done afterwards
    tick();
    in_valid = 1; alu_out = 16'h0040; rd = 6; reg_write = 1; mem_read = 1;
    tick();
    tick();
    @(negedge clk);
    chk("rb_in_busy_stall", stall_out, 1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rb_err", err, 0);
    chk("rb_wb_data", wb_data, 0);
    chk("rb_wb_valid", wb_valid, 0);
    chk("rb_mem_addr", mem_addr, 0);
    chk("rb_stall", stall_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_done = 1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("rb_done_stall", stall_out, 0);
    chk("rb_done_mem_rd", mem_rd, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rb_no_wb_valid", wb_valid, 0);
    chk("rb_no_wb_data", wb_data, 0);

    // Odd address load
    tick();
    in_valid = 1; alu_out = 16'h0011; rd = 1; reg_write = 1; mem_read = 1;
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    chk("al_stall", stall_out, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("al_mem_rd", mem_rd, 0);
    chk("al_err", err, 1);
    chk("al_wb_valid", wb_valid, 0);
`else
    @(negedge clk);
    chk("odd_stall", stall_out, 1);
    tick();
    mem_done = 1; mem_rdata = 16'h1357;
    @(negedge clk);
    chk("odd_mem_rd", mem_rd, 1);
    chk("odd_addr", mem_addr, 16'h0011);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("odd_wb_valid", wb_valid, 1);
    chk("odd_wb_data", wb_data, 16'h1357);
    chk("odd_err", err, 0);
`endif

    // Illegal read+write runs as an ALU op and flags err; halt propagates
    tick();
    in_valid = 1; alu_out = 16'h5555; rd = 7; reg_write = 1; halt_in = 1;
    mem_read = 1; mem_write = 1;
    @(negedge clk);
    chk("ill_stall", stall_out, 0);
    chk("ill_mem_rd", mem_rd, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_wb_valid", wb_valid, 1);
    chk("ill_wb_data", wb_data, 16'h5555);
    chk("ill_wb_rd", wb_rd, 7);
    chk("ill_wb_halt", wb_halt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
